// File: rtl/regfile_pkg.sv
// Shared register-file types: word/select widths and the writeback entry record.
package regfile_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback-queue bus: producer handshake, register file write port, bypass snoop and status.
// The slave modport is the queue; the master modport is the pipeline/regfile side.
interface regfile_wb_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import regfile_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  regbits_t                     in_sel;
  word_t                        in_dat;
  logic                         drain_en;
  logic                         WEN;
  regbits_t                     wsel;
  word_t                        wdat;
  regbits_t                     rsel1;
  regbits_t                     rsel2;
  logic                         byp_hit1;
  logic                         byp_hit2;
  word_t                        byp_dat1;
  word_t                        byp_dat2;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         empty;

  modport slave (
    input  in_valid, in_sel, in_dat, drain_en, rsel1, rsel2,
    output in_ready, WEN, wsel, wdat, byp_hit1, byp_hit2, byp_dat1, byp_dat2, count, empty
  );

  modport master (
    output in_valid, in_sel, in_dat, drain_en, rsel1, rsel2,
    input  in_ready, WEN, wsel, wdat, byp_hit1, byp_hit2, byp_dat1, byp_dat2, count, empty
  );

endinterface

// File: rtl/regfile_wbq_match.sv
// Bypass search for one read port: finds the youngest valid queue entry whose select
// matches rsel (rsel == 0 never hits) and returns its data.
module regfile_wbq_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]       entries,
  input  logic [DEPTH-1:0]            valid,
  input  logic [$clog2(DEPTH)-1:0]    tail,
  input  regbits_t                    rsel,
  output logic                        hit,
  output word_t                       dat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest-to-youngest relative to tail so the youngest match is the last one written.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PTR_W'(k + 1);
      if (valid[idx] && (entries[idx].sel == rsel) && (rsel != '0)) begin
        hit = 1'b1;
        dat = entries[idx].dat;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Register file writeback queue: FIFO of pending writes drained one per granted cycle onto
// WEN/wsel/wdat. Writes to r0 complete the handshake but are dropped.
// Optional macro REGFILE_WBQ_BYPASS_EN enables the read-select bypass search; without it
// byp_* outputs are tied to zero.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  regfile_wb_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop;

  // in_ready only depends on the registered count: no pass-through when full.
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && (bus.in_sel != '0);
  assign bus.empty    = (count_q == '0);
  assign pop          = !bus.empty && bus.drain_en;
  assign bus.count    = count_q;

  // Head entry presented on the write port; forced to zero when nothing is pending.
  always_comb begin
    bus.WEN  = pop;
    bus.wsel = '0;
    bus.wdat = '0;
    if (!bus.empty) begin
      bus.wsel = mem_q[head_q].sel;
      bus.wdat = mem_q[head_q].dat;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Entry storage; contents are masked by occupancy so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= '{sel: bus.in_sel, dat: bus.in_dat};
  end

`ifdef REGFILE_WBQ_BYPASS_EN
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] off;

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head_q;
      valid[i] = (CNT_W'(off) < count_q);
    end
  end

  regfile_wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_q),
    .valid   (valid),
    .tail    (tail_q),
    .rsel    (bus.rsel1),
    .hit     (bus.byp_hit1),
    .dat     (bus.byp_dat1)
  );

  regfile_wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_q),
    .valid   (valid),
    .tail    (tail_q),
    .rsel    (bus.rsel2),
    .hit     (bus.byp_hit2),
    .dat     (bus.byp_dat2)
  );
`else
  logic unused_rsel;
  assign unused_rsel  = ^{bus.rsel1, bus.rsel2};
  assign bus.byp_hit1 = 1'b0;
  assign bus.byp_hit2 = 1'b0;
  assign bus.byp_dat1 = '0;
  assign bus.byp_dat2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: scoreboard of expected register writes plus
// scenario tasks for reset, full/backpressure, bypass, r0 discard, wrap and mid-run reset.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

`ifdef REGFILE_WBQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;
  logic last_acc;
  wb_entry_t sb[$];

  regfile_wb_queue_if #(.DEPTH(4)) bus ();

  regfile_wb_queue #(.DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle: drive after posedge, sample at negedge, retire drains against the scoreboard.
  task automatic step(input logic v, input logic [4:0] s, input logic [31:0] d, input logic dr);
    wb_entry_t exp;
    @(posedge CLK);
    #1;
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_dat   = d;
    bus.drain_en = dr;
    @(negedge CLK);
    last_acc = v && bus.in_ready;
    if (bus.WEN === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL drain_unexpected: got wsel=%0d wdat=%h, required no write", bus.wsel,
                 bus.wdat);
      end else begin
        exp = sb.pop_front();
        if (bus.wsel !== exp.sel || bus.wdat !== exp.dat) begin
          n_bad++;
          $display("FAIL drain_order: got wsel=%0d wdat=%h, required wsel=%0d wdat=%h",
                   bus.wsel, bus.wdat, exp.sel, exp.dat);
        end
      end
    end
    if (last_acc && s != 5'd0) sb.push_back('{sel: s, dat: d});
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < 16 && !bus.empty; i++) step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (sb.size() != 0 || bus.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_drained: got pending=%0d empty=%b, required pending=0 empty=1", name,
               sb.size(), bus.empty);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sel   = 5'd0;
    bus.in_dat   = 32'd0;
    bus.drain_en = 1'b1;
    bus.rsel1    = 5'd5;
    bus.rsel2    = 5'd0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_status: got ready=%b empty=%b count=%0d, required 1 1 0",
               bus.in_ready, bus.empty, bus.count);
    end
    n_cmp++;
    if (bus.WEN !== 1'b0 || bus.wsel !== 5'd0 || bus.wdat !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_port: got WEN=%b wsel=%0d wdat=%h, required 0 0 0", bus.WEN,
               bus.wsel, bus.wdat);
    end
    n_cmp++;
    if (bus.byp_hit1 !== 1'b0 || bus.byp_dat1 !== 32'd0 || bus.byp_hit2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_bypass: got hit1=%b dat1=%h hit2=%b, required 0 0 0",
               bus.byp_hit1, bus.byp_dat1, bus.byp_hit2);
    end
    RST = 1'b0;
    bus.drain_en = 1'b0;
    bus.rsel1    = 5'd0;
  endtask

  task automatic test_basic();
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (bus.WEN !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_wen: got WEN=%b, required 1", bus.WEN);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.WEN !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL basic_after: got empty=%b WEN=%b pending=%0d, required 1 0 0", bus.empty,
               bus.WEN, sb.size());
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'hF000 + 32'(i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 5'd5, 32'h55, 1'b0);
      n_cmp++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || last_acc !== 1'b0) begin
        n_bad++;
        $display("FAIL full_hold: got count=%0d ready=%b acc=%b, required 4 0 0", bus.count,
                 bus.in_ready, last_acc);
      end
    end
    last_acc = 1'b0;
    for (int i = 0; i < 8 && !last_acc; i++) step(1'b1, 5'd5, 32'h55, 1'b1);
    n_cmp++;
    if (last_acc !== 1'b1) begin
      n_bad++;
      $display("FAIL full_fifth_accept: got acc=%b, required 1", last_acc);
    end
    drain_all("full");
  endtask

  task automatic test_bypass();
    step(1'b1, 5'd7, 32'h11, 1'b0);
    step(1'b1, 5'd7, 32'h22, 1'b0);
    step(1'b1, 5'd3, 32'h33, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    bus.rsel1 = 5'd7;
    bus.rsel2 = 5'd0;
    #1;
    n_cmp++;
    if (bus.byp_hit1 !== Byp || bus.byp_dat1 !== (Byp ? 32'h22 : 32'h0)) begin
      n_bad++;
      $display("FAIL byp_youngest: got hit1=%b dat1=%h, required %b %h", bus.byp_hit1,
               bus.byp_dat1, Byp, Byp ? 32'h22 : 32'h0);
    end
    n_cmp++;
    if (bus.byp_hit2 !== 1'b0 || bus.byp_dat2 !== 32'h0) begin
      n_bad++;
      $display("FAIL byp_r0: got hit2=%b dat2=%h, required 0 0", bus.byp_hit2, bus.byp_dat2);
    end
    bus.rsel2 = 5'd3;
    #1;
    n_cmp++;
    if (bus.byp_hit2 !== Byp || bus.byp_dat2 !== (Byp ? 32'h33 : 32'h0)) begin
      n_bad++;
      $display("FAIL byp_port2: got hit2=%b dat2=%h, required %b", bus.byp_hit2, bus.byp_dat2,
               Byp);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    // Head 7/0x22 is draining this cycle and must still be visible.
    n_cmp++;
    if (bus.WEN !== 1'b1 || bus.byp_hit1 !== Byp || bus.byp_dat1 !== (Byp ? 32'h22 : 32'h0))
    begin
      n_bad++;
      $display("FAIL byp_head_drain: got WEN=%b hit1=%b dat1=%h, required 1 %b", bus.WEN,
               bus.byp_hit1, bus.byp_dat1, Byp);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0);
    n_cmp++;
    if (bus.byp_hit1 !== 1'b0 || bus.byp_dat1 !== 32'h0 || bus.byp_hit2 !== Byp) begin
      n_bad++;
      $display("FAIL byp_after_drain: got hit1=%b dat1=%h hit2=%b, required 0 0 %b",
               bus.byp_hit1, bus.byp_dat1, bus.byp_hit2, Byp);
    end
    bus.rsel1 = 5'd0;
    bus.rsel2 = 5'd0;
    drain_all("bypass");
  endtask

  task automatic test_sel_zero();
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    n_cmp++;
    if (last_acc !== 1'b1) begin
      n_bad++;
      $display("FAIL r0_handshake: got acc=%b, required 1", last_acc);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (bus.count !== 3'd0 || bus.WEN !== 1'b0 || bus.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL r0_discard: got count=%0d WEN=%b empty=%b, required 0 0 1", bus.count,
               bus.WEN, bus.empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 20), 32'hA0 + 32'(i), 1'b0);
    for (int p = 0; p < 10; p++) begin
      step(1'b1, 5'((p % 31) + 1), 32'h1000 + 32'(p), 1'b1);
      n_cmp++;
      if (bus.count !== 3'd4 || last_acc !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_full_%0d: got count=%0d acc=%b, required 4 0", p, bus.count,
                 last_acc);
      end
      step(1'b1, 5'((p % 31) + 1), 32'h1000 + 32'(p), 1'b0);
      n_cmp++;
      if (last_acc !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_push_%0d: got acc=%b, required 1", p, last_acc);
      end
    end
    drain_all("wrap");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 5'(i + 10), 32'hB0 + 32'(i), 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (bus.WEN !== 1'b1 || bus.count !== 3'd3) begin
      n_bad++;
      $display("FAIL rstmid_pre: got WEN=%b count=%0d, required 1 3", bus.WEN, bus.count);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (bus.WEN !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1)
    begin
      n_bad++;
      $display("FAIL rstmid_async: got WEN=%b count=%0d empty=%b ready=%b, required 0 0 1 1",
               bus.WEN, bus.count, bus.empty, bus.in_ready);
    end
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1);
      n_cmp++;
      if (bus.WEN !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_quiet_%0d: got WEN=%b, required 0", i, bus.WEN);
      end
    end
    step(1'b1, 5'd9, 32'h99, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (bus.WEN !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_resume: got WEN=%b, required 1", bus.WEN);
    end
    drain_all("rstmid");
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_acc = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_bypass();
    test_sel_zero();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
